// File: rtl/rect_matrix_mult.sv
// rect_matrix_mult: single-MAC controller computing C = A*B or C += A*B for run-time sized matrices over the register-file bus
module rect_matrix_mult #(
    parameter int max_dim       = 4,
    parameter int cell_width    = 8,
    parameter int address_width = 8,
    parameter int width         = cell_width * max_dim,
    parameter int dim_width     = $clog2(max_dim + 1)
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic                     in_start,
    input  logic [dim_width-1:0]     in_rows,
    input  logic [dim_width-1:0]     in_inner,
    input  logic [dim_width-1:0]     in_cols,
    input  logic                     in_mode,
    input  logic [width-1:0]         in_data,
    input  logic                     in_data_ready,
    input  logic                     in_ack,
    output logic [address_width-1:0] out_reg_address,
    output logic [1:0]               out_type,
    output logic [1:0]               out_matrix,
    output logic                     out_read_en,
    output logic                     out_write_en,
    output logic [cell_width-1:0]    out_cell_c,
    output logic                     out_busy,
    output logic                     out_ready,
    output logic                     out_error
);
    localparam int acc_width = 2 * cell_width + dim_width;
    localparam logic [dim_width-1:0] dim_max = dim_width'(max_dim);
    typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, FETCH_C, MAC, WRITE, DONE} state_t;
    state_t r_state, w_next;
    logic [dim_width-1:0] r_rows, r_inner, r_cols, r_i, r_j, r_k;
    logic r_mode, r_error;
    logic [width-1:0] r_row_a, r_col_b;
    logic [acc_width-1:0] r_acc;
    logic [cell_width-1:0] w_a, w_b;
    logic [2*cell_width-1:0] w_prod;
    logic [address_width-1:0] w_row_addr, w_cell_addr;
    logic w_dim_bad, w_last_k, w_last_j, w_last_i;

    assign w_dim_bad = in_rows == '0 || in_inner == '0 || in_cols == '0 ||
                       in_rows > dim_max || in_inner > dim_max || in_cols > dim_max;
    assign w_a = r_row_a[int'(r_k) * cell_width +: cell_width];
    assign w_b = r_col_b[int'(r_k) * cell_width +: cell_width];
    assign w_prod = w_a * w_b;
    assign w_row_addr = address_width'(r_i) * address_width'(max_dim);
    assign w_cell_addr = w_row_addr + address_width'(r_j);
    assign w_last_k = r_k == r_inner - dim_width'(1);
    assign w_last_j = r_j == r_cols - dim_width'(1);
    assign w_last_i = r_i == r_rows - dim_width'(1);

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_start ? (w_dim_bad ? DONE : FETCH_A) : IDLE;
            FETCH_A: w_next = in_data_ready ? FETCH_B : FETCH_A;
            FETCH_B: w_next = in_data_ready ? (r_mode ? FETCH_C : MAC) : FETCH_B;
            FETCH_C: w_next = in_data_ready ? MAC : FETCH_C;
            MAC:     w_next = w_last_k ? WRITE : MAC;
            WRITE:   w_next = !w_last_j ? FETCH_B : (w_last_i ? DONE : FETCH_A);
            DONE:    w_next = in_ack ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        out_read_en = r_state == FETCH_A || r_state == FETCH_B || r_state == FETCH_C;
        out_write_en = r_state == WRITE;
        out_type = r_state == FETCH_A ? 2'b01 : (r_state == FETCH_B ? 2'b10 : 2'b00);
        out_matrix = r_state == FETCH_B ? 2'b01 :
                     (r_state == FETCH_C || r_state == WRITE) ? 2'b10 : 2'b00;
        out_reg_address = r_state == FETCH_A ? w_row_addr :
                          r_state == FETCH_B ? address_width'(r_j) :
                          (r_state == FETCH_C || r_state == WRITE) ? w_cell_addr : '0;
        out_cell_c = out_write_en ? r_acc[cell_width-1:0] : '0;
        out_busy = r_state != IDLE && r_state != DONE;
        out_ready = r_state == DONE;
        out_error = out_ready && r_error;
    end

    // A row stays in r_row_a for every column of that row; the accumulator is reseeded per cell
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            r_rows  <= '0;
            r_inner <= '0;
            r_cols  <= '0;
            r_mode  <= 1'b0;
            r_error <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_row_a <= '0;
            r_col_b <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_start) begin
                    r_rows  <= in_rows;
                    r_inner <= in_inner;
                    r_cols  <= in_cols;
                    r_mode  <= in_mode;
                    r_error <= w_dim_bad;
                    r_i     <= '0;
                    r_j     <= '0;
                end
                FETCH_A: if (in_data_ready) r_row_a <= in_data;
                FETCH_B: if (in_data_ready) begin
                    r_col_b <= in_data;
                    r_acc   <= '0;
                    r_k     <= '0;
                end
                FETCH_C: if (in_data_ready) r_acc <= acc_width'(in_data[cell_width-1:0]);
                MAC: begin
                    r_acc <= r_acc + acc_width'(w_prod);
                    r_k   <= r_k + dim_width'(1);
                end
                WRITE: begin
                    r_j <= w_last_j ? '0 : r_j + dim_width'(1);
                    if (w_last_j) r_i <= r_i + dim_width'(1);
                end
                DONE: if (in_ack) r_error <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/rect_matrix_mult.md
# rect_matrix_mult

Sequential controller that computes C = A × B (overwrite) or C = C + A × B (accumulate) for rectangular matrices of run-time size (rows × inner) · (inner × cols), up to max_dim in each dimension. It sits between the coprocessor command decoder and the shared matrix register file. It uses the same address/type/matrix read-write request bus as the square multiplier. An internal single-MAC datapath replaces the external column processor.

## Interface
- max_dim, 4, largest legal rows/inner/cols; register-file row stride
- cell_width, 8, bits per matrix element (unsigned)
- address_width, 8, register-file address width
- width, cell_width*max_dim, packed row/column vector width
- dim_width, $clog2(max_dim+1), width of dimension inputs
- in_clk  input  1  single clock, all state on rising edge
- in_reset  input  1  asynchronous, active-high reset
- in_start  input  1  start request, sampled only in IDLE
- in_rows, in_inner, in_cols  input  dim_width each  dimensions, latched on accepted start
- in_mode  input  1  0 = overwrite, 1 = accumulate; latched on start
- in_data  input  width  read data; element k at [k*cell_width +: cell_width]
- in_data_ready  input  1  read data valid this cycle
- in_ack  input  1  host acknowledge of completion
- out_reg_address  output  address_width  request address
- out_type  output  2  00 cell, 01 row, 10 column
- out_matrix  output  2  00 A, 01 B, 10 C
- out_read_en, out_write_en  output  1 each  request strobes
- out_cell_c  output  cell_width  write data
- out_busy  output  1  high from accepted start until DONE
- out_ready  output  1  completion flag
- out_error  output  1  dimension error flag, valid while out_ready

## Operation
- Reset: all outputs 0, counters 0, state IDLE. Reset mid-operation aborts immediately. No partial write completes after reset asserts.
- States: IDLE, FETCH_A, FETCH_B, FETCH_C, MAC, WRITE, DONE.
- IDLE: if in_start, latch dims and mode. Any dim 0 or > max_dim → DONE with out_error=1, no bus traffic. Otherwise go to FETCH_A with i=j=0.
- FETCH_A: row request, address i*max_dim, type 01, matrix 00. A row is fetched once per i and reused across all j.
- FETCH_B: column request, address j, type 10, matrix 01.
- FETCH_C (mode 1 only): cell request, address i*max_dim+j, type 00, matrix 10. Captured as the accumulator seed. Mode 0 seeds 0.
- MAC: one product per cycle, k = 0..inner-1. Accumulator is 2*cell_width+dim_width bits, unsigned, no overflow inside.
- WRITE: one-cycle write of the low cell_width bits of the accumulator (modulo 2^cell_width) to address i*max_dim+j, type 00, matrix 10. Then j+1 → FETCH_B. If j = cols-1, set j=0, i+1 → FETCH_A. If i = rows-1, go to DONE.
- Elements with index ≥ inner in fetched vectors are ignored.
- DONE: out_ready=1, out_busy=0. Hold until in_ack, then go to IDLE and clear out_ready/out_error. in_start is ignored outside IDLE.

## Timing
- Fetch handshake: read_en, address, type and matrix assert on the edge entering the fetch state. They hold steady until the edge on which in_data_ready is sampled high. in_data is captured on that edge and read_en drops on the same edge.
- With in_data_ready high in the first request cycle, a fetch occupies exactly 1 cycle. Each wait cycle adds 1.
- in_data_ready while not fetching is ignored.
- MAC takes exactly inner cycles. WRITE takes 1 cycle, with out_write_en high for exactly 1 cycle and out_cell_c valid in the same cycle. out_cell_c is 0 otherwise.
- Zero-wait latency, from the start-accept edge to out_ready high: rows*(1 + cols*(inner + 2 + mode)) + 1 cycles.
- Error path: out_ready high 1 cycle after start accept.
- out_ready and in_ack high together: return to IDLE on that edge. A same-cycle in_start is not accepted until the next cycle.

## Test plan
- Rectangular overwrite: A = [[1,2,3],[4,5,6]], B = [[7,8],[9,10],[11,12]], dims 2/3/2, zero-wait → writes C[0]=58, C[1]=64, C[4]=139, C[5]=154; exactly 4 write pulses; out_ready at cycle 2*(1+2*5)+1 = 23.
- Accumulate: same A and B, C preloaded with all 1s, mode 1 → 59, 65, 140, 155; one C cell read precedes each write.
- Truncation: max_dim 4, A row [255,255], B column [255,255], inner 2, rows=cols=1 → out_cell_c = 2 (130050 mod 256).
- Dimension error: in_cols = 0, then separately in_rows = 5 → out_ready and out_error high 1 cycle after start; no read_en or write_en ever asserted; in_ack returns to IDLE.
- Wait states: in_data_ready delayed 3 cycles on every fetch → address and strobes stable throughout each wait; results identical to the first scenario.
- Reset mid-MAC: assert in_reset during the second cell's MAC → all outputs 0 in the same cycle; no write for that cell; a new start then runs the first scenario correctly.
